// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl: clocked exhaustive sweep of an N_IN-input, 1-output
// combinational block. Drives every input vector, captures the block's output
// into a truth table, and compares it with an expected table latched at start.
//
// Optional feature macro: TT_SWEEP_FIRST_FAIL_EN
//   When defined, adds first_fail_valid / first_fail_idx. These record the
//   index of the first mismatching vector in the current sweep.
`timescale 1ns/1ps

module tt_sweep_ctrl #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1   // extra wait cycles per vector, 0..15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [(1<<N_IN)-1:0]   expected,
  input  logic                   dut_y,
  output logic [N_IN-1:0]        dut_in,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   table_out,
  output logic                   pass,
`ifdef TT_SWEEP_FIRST_FAIL_EN
  output logic                   first_fail_valid,
  output logic [N_IN-1:0]        first_fail_idx,
`endif
  output logic [N_IN:0]          mismatch_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  localparam logic [3:0]      SETTLE_V = 4'(SETTLE);
  localparam logic [3:0]      CNT_ONE  = 4'd1;
  localparam logic [N_IN-1:0] IDX_ONE  = N_IN'(1);
  // The last vector is found by comparison with all-ones, never by wrap-around.
  localparam logic [N_IN-1:0] LAST_IDX = '1;
  localparam logic [N_IN:0]   MM_ONE   = (N_IN+1)'(1);

  state_t                 state;
  logic [3:0]             settle_cnt;
  logic [(1<<N_IN)-1:0]   exp_q;

  // dut_in doubles as the sweep index: both always hold the same value.

  // Sweep sequencer: one registered FSM producing every output.
  // NOTE: all state here is updated with non-blocking assignments so that
  // reads within the block see the pre-edge values (e.g. mismatch_cnt in FINISH).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: exp_q is an ordinary register, so it is reset along with the rest
      // to keep every flop deterministic out of reset.
      state        <= S_IDLE;
      settle_cnt   <= '0;
      exp_q        <= '0;
      dut_in       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      table_out    <= '0;
      pass         <= 1'b0;
      mismatch_cnt <= '0;
`ifdef TT_SWEEP_FIRST_FAIL_EN
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // start wins over abort here; abort has no effect in IDLE.
          if (start) begin
            exp_q        <= expected;
            dut_in       <= '0;
            settle_cnt   <= SETTLE_V;
            table_out    <= '0;
            mismatch_cnt <= '0;
            pass         <= 1'b0;
            busy         <= 1'b1;
            state        <= S_WAIT;
`ifdef TT_SWEEP_FIRST_FAIL_EN
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
`endif
          end
        end

        S_WAIT: begin
          if (abort) begin
            // Partial table_out / mismatch_cnt are kept for inspection.
            state  <= S_IDLE;
            busy   <= 1'b0;
            pass   <= 1'b0;
            dut_in <= '0;
          end else if (settle_cnt != 4'd0) begin
            settle_cnt <= settle_cnt - CNT_ONE;
          end else begin
            table_out[dut_in] <= dut_y;
            if (dut_y != exp_q[dut_in]) begin
              mismatch_cnt <= mismatch_cnt + MM_ONE;
`ifdef TT_SWEEP_FIRST_FAIL_EN
              if (!first_fail_valid) begin
                first_fail_valid <= 1'b1;
                first_fail_idx   <= dut_in;
              end
`endif
            end
            if (dut_in == LAST_IDX) begin
              state <= S_FINISH;
              busy  <= 1'b0;
            end else begin
              dut_in     <= dut_in + IDX_ONE;
              settle_cnt <= SETTLE_V;
            end
          end
        end

        S_FINISH: begin
          if (abort) begin
            state  <= S_IDLE;
            pass   <= 1'b0;
            dut_in <= '0;
          end else begin
            // mismatch_cnt already includes the last sample taken on entry.
            done  <= 1'b1;
            pass  <= (mismatch_cnt == '0);
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Testbench for tt_sweep_ctrl: table-driven sweeps on a SETTLE=1 instance
// driving a majority block, plus hand-written abort, restart, reset and
// SETTLE=0 sequences.
`timescale 1ns/1ps

module tb_tt_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;

  // Instance 0: SETTLE=1, swept block = majority(a,b,c) ^ inv0
  logic       start0, abort0, inv0;
  logic [7:0] exp0;
  logic       y0;
  logic [2:0] dut_in0;
  logic       busy0, done0, pass0;
  logic [7:0] tbl0;
  logic [3:0] mm0;

  // Instance 1: SETTLE=0, swept block = ~a
  logic       start1, abort1;
  logic [7:0] exp1;
  logic       y1;
  logic [2:0] dut_in1;
  logic       busy1, done1, pass1;
  logic [7:0] tbl1;
  logic [3:0] mm1;

`ifdef TT_SWEEP_FIRST_FAIL_EN
  logic       ffv0, ffv1;
  logic [2:0] ffi0, ffi1;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign y0 = ((dut_in0[0] & dut_in0[1]) | (dut_in0[0] & dut_in0[2]) |
               (dut_in0[1] & dut_in0[2])) ^ inv0;
  assign y1 = ~dut_in1[0];

  tt_sweep_ctrl #(.N_IN(3), .SETTLE(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
    .expected(exp0), .dut_y(y0), .dut_in(dut_in0), .busy(busy0),
    .done(done0), .table_out(tbl0), .pass(pass0),
`ifdef TT_SWEEP_FIRST_FAIL_EN
    .first_fail_valid(ffv0), .first_fail_idx(ffi0),
`endif
    .mismatch_cnt(mm0)
  );

  tt_sweep_ctrl #(.N_IN(3), .SETTLE(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .expected(exp1), .dut_y(y1), .dut_in(dut_in1), .busy(busy1),
    .done(done1), .table_out(tbl1), .pass(pass1),
`ifdef TT_SWEEP_FIRST_FAIL_EN
    .first_fail_valid(ffv1), .first_fail_idx(ffi1),
`endif
    .mismatch_cnt(mm1)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Sweep on instance 0. Returns done latency in cycles after the start edge
  // (-1 if the budget expires) and whether dut_in/busy stepped as expected.
  // mid_start re-pulses start (with a different table) before edge k+4.
  task automatic sweep0(input logic [7:0] e, input bit mid_start,
                        output int lat, output bit seq_ok);
    int exp_di;
    exp0   = e;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    seq_ok = (busy0 === 1'b1) && (dut_in0 === 3'd0);
    lat    = -1;
    for (int c = 1; c <= 40; c++) begin
      if (mid_start && c == 4) begin
        start0 = 1'b1;
        exp0   = 8'h00;
      end
      @(posedge clk); #1;
      start0 = 1'b0;
      if (done0 === 1'b1) begin
        lat = c;
        break;
      end
      exp_di = (c / 2 > 7) ? 7 : c / 2;
      if (dut_in0 !== 3'(exp_di)) seq_ok = 1'b0;
      if (busy0 !== (c < 16)) seq_ok = 1'b0;
    end
  endtask

  typedef struct {
    logic       inv;
    logic [7:0] expct;
    logic [7:0] tbl;
    logic       ps;
    logic [3:0] mm;
    logic       ffv;
    logic [2:0] ffi;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int  lat;
    bit  seq_ok;
    bit  flag;

    // {inv, expected, table_out, pass, mismatch_cnt, ff_valid, ff_idx}
    vecs[0] = '{1'b0, 8'hE8, 8'hE8, 1'b1, 4'd0, 1'b0, 3'd0};
    vecs[1] = '{1'b0, 8'hE9, 8'hE8, 1'b0, 4'd1, 1'b1, 3'd0};
    vecs[2] = '{1'b0, 8'h00, 8'hE8, 1'b0, 4'd4, 1'b1, 3'd3};
    vecs[3] = '{1'b0, 8'h17, 8'hE8, 1'b0, 4'd8, 1'b1, 3'd0};
    vecs[4] = '{1'b1, 8'h17, 8'h17, 1'b1, 4'd0, 1'b0, 3'd0};
    vecs[5] = '{1'b1, 8'hE8, 8'h17, 1'b0, 4'd8, 1'b1, 3'd0};

    rst_n = 1'b0;
    start0 = 1'b0; abort0 = 1'b0; inv0 = 1'b0; exp0 = 8'h00;
    start1 = 1'b0; abort1 = 1'b0; exp1 = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy0",  busy0,   1'b0);
    check("rst done0",  done0,   1'b0);
    check("rst dut_in0", dut_in0, 3'd0);
    check("rst tbl0",   tbl0,    8'h00);
    check("rst pass0",  pass0,   1'b0);
    check("rst mm0",    mm0,     4'd0);
    check("rst busy1",  busy1,   1'b0);
    check("rst tbl1",   tbl1,    8'h00);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven full sweeps
    foreach (vecs[i]) begin
      inv0 = vecs[i].inv;
      sweep0(vecs[i].expct, 1'b0, lat, seq_ok);
      check($sformatf("v%0d latency", i), lat, 17);
      check($sformatf("v%0d sequence", i), seq_ok, 1'b1);
      check($sformatf("v%0d table", i), tbl0, vecs[i].tbl);
      check($sformatf("v%0d pass", i), pass0, vecs[i].ps);
      check($sformatf("v%0d mismatch", i), mm0, vecs[i].mm);
`ifdef TT_SWEEP_FIRST_FAIL_EN
      check($sformatf("v%0d ff_valid", i), ffv0, vecs[i].ffv);
      check($sformatf("v%0d ff_idx", i), ffi0, vecs[i].ffi);
`endif
      @(posedge clk); #1;
      check($sformatf("v%0d done one-shot", i), done0, 1'b0);
      check($sformatf("v%0d pass hold", i), pass0, vecs[i].ps);
    end

    // start during a sweep is ignored; start right after done is accepted
    inv0 = 1'b0;
    sweep0(8'hE8, 1'b1, lat, seq_ok);
    check("midstart latency", lat, 17);
    check("midstart sequence", seq_ok, 1'b1);
    check("midstart table", tbl0, 8'hE8);
    check("midstart pass", pass0, 1'b1);
    check("midstart mismatch", mm0, 4'd0);
    sweep0(8'hE9, 1'b0, lat, seq_ok);
    check("back2back latency", lat, 17);
    check("back2back sequence", seq_ok, 1'b1);
    check("back2back mismatch", mm0, 4'd1);
    check("back2back pass", pass0, 1'b0);

    // abort in WAIT after vectors 0..2 have been sampled
    inv0 = 1'b1;
    exp0 = 8'hE8;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    abort0 = 1'b1;
    @(posedge clk); #1;
    abort0 = 1'b0;
    check("abort busy", busy0, 1'b0);
    check("abort dut_in", dut_in0, 3'd0);
    check("abort pass", pass0, 1'b0);
    check("abort table", tbl0, 8'h07);
    check("abort mismatch", mm0, 4'd3);
`ifdef TT_SWEEP_FIRST_FAIL_EN
    check("abort ff_valid", ffv0, 1'b1);
    check("abort ff_idx", ffi0, 3'd0);
`endif
    flag = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (done0 !== 1'b0 || busy0 !== 1'b0) flag = 1'b1;
    end
    check("abort no done", flag, 1'b0);

    // abort in FINISH suppresses done and forces pass low
    inv0 = 1'b0;
    exp0 = 8'hE8;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    abort0 = 1'b1;
    @(posedge clk); #1;
    abort0 = 1'b0;
    flag = done0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done0 !== 1'b0) flag = 1'b1;
    end
    check("finish-abort no done", flag, 1'b0);
    check("finish-abort pass", pass0, 1'b0);
    check("finish-abort table", tbl0, 8'hE8);
    check("finish-abort dut_in", dut_in0, 3'd0);

    // start and abort together in IDLE: start wins
    exp0 = 8'hE8;
    start0 = 1'b1;
    abort0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    abort0 = 1'b0;
    check("start+abort busy", busy0, 1'b1);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done0 === 1'b1) begin
        lat = c;
        break;
      end
    end
    check("start+abort latency", lat, 17);
    check("start+abort pass", pass0, 1'b1);

    // asynchronous reset mid-sweep
    inv0 = 1'b1;
    exp0 = 8'hE8;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst busy", busy0, 1'b0);
    check("midrst dut_in", dut_in0, 3'd0);
    check("midrst table", tbl0, 8'h00);
    check("midrst mismatch", mm0, 4'd0);
    check("midrst pass", pass0, 1'b0);
    check("midrst done", done0, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    inv0 = 1'b0;
    sweep0(8'hE8, 1'b0, lat, seq_ok);
    check("postrst latency", lat, 17);
    check("postrst sequence", seq_ok, 1'b1);
    check("postrst table", tbl0, 8'hE8);
    check("postrst pass", pass0, 1'b1);

    // SETTLE=0 instance, y = ~a, expected all zero
    exp1 = 8'h00;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    seq_ok = (busy1 === 1'b1) && (dut_in1 === 3'd0);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done1 === 1'b1) begin
        lat = c;
        break;
      end
      if (dut_in1 !== 3'((c > 7) ? 7 : c)) seq_ok = 1'b0;
      if (busy1 !== (c < 8)) seq_ok = 1'b0;
    end
    check("s0 latency", lat, 9);
    check("s0 sequence", seq_ok, 1'b1);
    check("s0 table", tbl1, 8'h55);
    check("s0 mismatch", mm1, 4'd4);
    check("s0 pass", pass1, 1'b0);
`ifdef TT_SWEEP_FIRST_FAIL_EN
    check("s0 ff_valid", ffv1, 1'b1);
    check("s0 ff_idx", ffi1, 3'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
